// File: rtl/cache_instructions.sv
// cache_instructions: read-only direct-mapped instruction cache; a miss refills one whole line
// with a single read burst from the RAM controller.
module cache_instructions #(
   parameter int ADDRESS_BITWIDTH         = 32,
   parameter int LINE_IX_BITWIDTH         = 1,
   parameter int DATA_BITWIDTH            = 32,
   parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
   parameter int RAM_DEPTH_BITWIDTH       = 4,
   parameter int RAM_BURST_DATA_BITWIDTH  = 64,
   parameter int RAM_BURST_DATA_COUNT     = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic [ADDRESS_BITWIDTH-1:0]        address,
   output logic [DATA_BITWIDTH-1:0]           data,
   output logic                               data_ready,
   output logic                               busy,
   output logic                               br_cmd,
   output logic                               br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
   input  logic                               br_rd_data_valid,
   input  logic                               br_busy
);
   localparam int OFF_W   = $clog2(DATA_BITWIDTH / 8);
   localparam int WIX     = DATA_IX_IN_LINE_BITWIDTH;
   localparam int LIX     = LINE_IX_BITWIDTH;
   localparam int LINES   = 1 << LIX;
   localparam int WORDS   = 1 << WIX;
   localparam int WPB     = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
   localparam int WPB_W   = $clog2(WPB);
   localparam int BEAT_W  = $clog2(RAM_BURST_DATA_COUNT);
   localparam int TAG_LSB = OFF_W + WIX + LIX;
   localparam int TAG_W   = ADDRESS_BITWIDTH - TAG_LSB;
   localparam int RAM_SH  = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

   typedef enum logic [1:0] {IDLE, WAIT_RAM, FILL} state_t;

   state_t                    state_q;
   logic [LINES-1:0]          valid_q;
   logic [TAG_W-1:0]          tag_q [LINES];
   logic [DATA_BITWIDTH-1:0]  words_q [LINES][WORDS];
   logic [LIX-1:0]            req_line_q;
   logic [WIX-1:0]            req_word_q;
   logic [TAG_W-1:0]          req_tag_q;
   logic [BEAT_W-1:0]         beat_q;
   logic [DATA_BITWIDTH-1:0]  data_q;
   logic                      data_ready_q;
   logic                      busy_q;
   logic                      br_cmd_en_q;
   logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q;

   logic [LIX-1:0]              in_line;
   logic [WIX-1:0]              in_word;
   logic [TAG_W-1:0]            in_tag;
   logic                        hit;
   logic [ADDRESS_BITWIDTH-1:0] ram_entry;
   logic [BEAT_W-1:0]           req_beat;
   logic [WPB_W-1:0]            req_sub;
   logic [DATA_BITWIDTH-1:0]    fill_data;
   logic                        unused_bits;

   assign in_word   = address[OFF_W +: WIX];
   assign in_line   = address[OFF_W + WIX +: LIX];
   assign in_tag    = address[TAG_LSB +: TAG_W];
   assign hit       = valid_q[in_line] && tag_q[in_line] == in_tag;
   assign ram_entry = (address >> RAM_SH) & ~ADDRESS_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);
   assign req_beat  = req_word_q[WIX-1:WPB_W];
   assign req_sub   = req_word_q[WPB_W-1:0];
   // The requested word may arrive in the very last beat, before storage has been written.
   assign fill_data = req_beat == beat_q ? br_rd_data[req_sub * DATA_BITWIDTH +: DATA_BITWIDTH]
                                         : words_q[req_line_q][req_word_q];
   assign unused_bits = ^{address[OFF_W-1:0], ram_entry[ADDRESS_BITWIDTH-1:RAM_DEPTH_BITWIDTH]};

   assign data       = data_q;
   assign data_ready = data_ready_q;
   assign busy       = busy_q;
   assign br_cmd     = 1'b0;
   assign br_cmd_en  = br_cmd_en_q;
   assign br_addr    = br_addr_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         req_line_q   <= '0;
         req_word_q   <= '0;
         req_tag_q    <= '0;
         beat_q       <= '0;
         data_q       <= '0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         br_cmd_en_q  <= 1'b0;
         br_addr_q    <= '0;
      end else begin
         data_ready_q <= 1'b0;
         br_cmd_en_q  <= 1'b0;
         case (state_q)
            IDLE: if (enable) begin
               if (hit) begin
                  data_q       <= words_q[in_line][in_word];
                  data_ready_q <= 1'b1;
               end else begin
                  req_line_q <= in_line;
                  req_word_q <= in_word;
                  req_tag_q  <= in_tag;
                  br_addr_q  <= ram_entry[RAM_DEPTH_BITWIDTH-1:0];
                  beat_q     <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= WAIT_RAM;
               end
            end
            WAIT_RAM: if (!br_busy) begin
               br_cmd_en_q <= 1'b1;
               state_q     <= FILL;
            end
            FILL: if (br_rd_data_valid) begin
               for (int j = 0; j < WPB; j++)
                  words_q[req_line_q][{beat_q, WPB_W'(j)}] <= br_rd_data[j * DATA_BITWIDTH +: DATA_BITWIDTH];
               beat_q <= beat_q + BEAT_W'(1);
               if (beat_q == BEAT_W'(RAM_BURST_DATA_COUNT - 1)) begin
                  valid_q[req_line_q] <= 1'b1;
                  tag_q[req_line_q]   <= req_tag_q;
                  data_q              <= fill_data;
                  data_ready_q        <= 1'b1;
                  busy_q              <= 1'b0;
                  state_q             <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_instructions.sv
// tb_cache_instructions: directed stimulus with a queue scoreboard; a monitor pops expected
// words on data_ready and expected burst addresses on br_cmd_en.
module tb_cache_instructions;
   logic        clk = 1'b0;
   logic        rst, enable;
   logic [31:0] address, data;
   logic        data_ready, busy, br_cmd, br_cmd_en;
   logic [3:0]  br_addr;
   logic [63:0] br_rd_data;
   logic        br_rd_data_valid, br_busy;

   int          total = 0, bad = 0;
   logic [31:0] exp_q[$];
   int          cmd_q[$];
   logic [31:0] last_exp = '0;
   int          beat_limit = 4;
   bit          gap_en = 1'b0;
   int          stale_go = 0;

   always #5 clk = ~clk;

   cache_instructions dut (
      .clk(clk), .rst(rst), .enable(enable), .address(address), .data(data),
      .data_ready(data_ready), .busy(busy), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
      .br_addr(br_addr), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
      .br_busy(br_busy)
   );

   function automatic logic [31:0] ram_word(input int n);
      return n < 8 ? 32'(n) * 32'h1111_1111 : 32'hA000_0000 + 32'(n);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic pdr = 1'b0, pcmd = 1'b0;
      forever begin
         @(negedge clk);
         if (data_ready === 1'b1) begin
            chk("data_ready_pulse", pdr, 0);
            if (exp_q.size() == 0) chk("unexpected_data_ready", data_ready, 0);
            else begin
               last_exp = exp_q.pop_front();
               chk("data", data, last_exp);
            end
         end
         if (br_cmd_en === 1'b1) begin
            chk("cmd_pulse", pcmd, 0);
            chk("br_cmd", br_cmd, 0);
            if (cmd_q.size() == 0) chk("unexpected_cmd", br_cmd_en, 0);
            else chk("br_addr", br_addr, cmd_q.pop_front());
         end
         pdr  = data_ready;
         pcmd = br_cmd_en;
      end
   endtask

   task automatic ram_loop();
      int  base = 0, k = 0, left = 0, seen = 0;
      bit  tog = 1'b0;
      br_rd_data       = '0;
      br_rd_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         br_rd_data_valid = 1'b0;
         tog = !tog;
         if (stale_go != seen) begin
            seen = stale_go;
            k    = 2;
            left = 2;
         end else if (br_cmd_en === 1'b1) begin
            base = int'(br_addr);
            k    = 0;
            left = beat_limit;
         end else if (left > 0 && (!gap_en || tog)) begin
            br_rd_data       = {ram_word(2 * (base + k) + 1), ram_word(2 * (base + k))};
            br_rd_data_valid = 1'b1;
            k++;
            left--;
         end
      end
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] w, input bit miss, input int ba,
                      input bit want_data);
      @(negedge clk);
      enable  = 1'b1;
      address = a;
      if (want_data) exp_q.push_back(w);
      if (miss) cmd_q.push_back(ba);
      @(negedge clk);
      enable = 1'b0;
      chk("busy_after_req", busy, miss);
      chk("hit_latency", data_ready, !miss);
   endtask

   task automatic settle();
      int n = 0;
      while ((exp_q.size() != 0 || cmd_q.size() != 0 || busy !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drained", exp_q.size() + cmd_q.size(), 0);
      chk("busy_clear", busy, 0);
      @(negedge clk);
      chk("data_hold", data, last_exp);
   endtask

   task automatic check_reset_outputs();
      chk("rst_data", data, 0);
      chk("rst_data_ready", data_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_br_cmd", br_cmd, 0);
      chk("rst_br_cmd_en", br_cmd_en, 0);
      chk("rst_br_addr", br_addr, 0);
   endtask

   task automatic stimulus();
      int n;
      rst = 1'b0; enable = 1'b0; address = '0; br_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      // cold miss, hit in the same line
      req(32'h0C, 32'h3333_3333, 1, 0, 1);
      settle();
      req(32'h18, 32'h6666_6666, 0, 0, 1);
      settle();
      // second line with gapped beats; line 0 must survive
      gap_en = 1'b1;
      req(32'h20, 32'hA000_0008, 1, 4, 1);
      settle();
      gap_en = 1'b0;
      req(32'h04, 32'h1111_1111, 0, 0, 1);
      settle();
      // conflict miss evicts line 0, then the old tag misses again
      req(32'h40, 32'hA000_0010, 1, 8, 1);
      settle();
      req(32'h00, 32'h0000_0000, 1, 0, 1);
      settle();
      req(32'h24, 32'hA000_0009, 0, 0, 1);
      settle();
      // RAM backpressure with ignored enables while busy
      br_busy = 1'b1;
      req(32'h5C, 32'hA000_0017, 1, 8, 1);
      for (int i = 0; i < 5; i++) begin
         enable  = 1'b1;
         address = 32'h04;
         @(negedge clk);
         enable = 1'b0;
         chk("bp_no_cmd", br_cmd_en, 0);
         chk("bp_busy", busy, 1);
      end
      br_busy = 1'b0;
      @(negedge clk);
      chk("bp_cmd_first_free", br_cmd_en, 1);
      settle();
      // reset after two beats, then stale beats, then a fresh request
      beat_limit = 2;
      req(32'h08, 32'h2222_2222, 1, 0, 0);
      n = 0;
      while (cmd_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_cmd_seen", cmd_q.size(), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      stale_go++;
      repeat (6) @(negedge clk);
      chk("stale_busy", busy, 0);
      chk("stale_data", data, 0);
      beat_limit = 4;
      req(32'h08, 32'h2222_2222, 1, 0, 1);
      settle();
      req(32'h24, 32'hA000_0009, 1, 4, 1);
      settle();
   endtask

   initial begin
      fork
         monitor();
         ram_loop();
         stimulus();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
